// File: rtl/se_relu_collector.sv
// Frame collector for ReLU samples: gathers NUM_CHANNELS samples into a register
// buffer, then drains them over a valid/ready stream while the input is ignored.
module se_relu_collector #(
    parameter int DATA_WIDTH   = 16,
    parameter int NUM_CHANNELS = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic                  frame_done,
    output logic                  overflow
);

    localparam int IDX_W = $clog2(NUM_CHANNELS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHANNELS - 1);

    typedef enum logic {COLLECT = 1'b0, DRAIN = 1'b1} state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [DATA_WIDTH-1:0] r_buf [NUM_CHANNELS];
    logic [IDX_W-1:0]      r_wr_idx;
    logic [IDX_W-1:0]      r_rd_idx;
    logic                  r_frame_done;
    logic                  r_overflow;
    logic                  w_wr_en;
    logic                  w_wr_last;
    logic                  w_xfer;
    logic                  w_xfer_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= COLLECT;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_wr_en     = 1'b0;
        w_wr_last   = 1'b0;
        w_xfer      = 1'b0;
        w_xfer_last = 1'b0;
        case (r_state)
            COLLECT: begin
                w_wr_en   = in_valid;
                w_wr_last = in_valid && (r_wr_idx == LAST_IDX);
                if (w_wr_last) w_state_nxt = DRAIN;
            end
            DRAIN: begin
                w_xfer      = out_ready;
                w_xfer_last = out_ready && (r_rd_idx == LAST_IDX);
                if (w_xfer_last) w_state_nxt = COLLECT;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CHANNELS; i++) r_buf[i] <= '0;
        end else if (w_wr_en) begin
            r_buf[r_wr_idx] <= in_data;
        end
    end

    // Indices wrap explicitly so non-power-of-two channel counts stay in range.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_idx <= '0;
            r_rd_idx <= '0;
        end else begin
            if (w_wr_en) r_wr_idx <= w_wr_last ? '0 : r_wr_idx + 1'b1;
            if (w_wr_last)   r_rd_idx <= '0;
            else if (w_xfer) r_rd_idx <= w_xfer_last ? '0 : r_rd_idx + 1'b1;
        end
    end

    // Input arriving while draining is lost; the flag stays up until reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_frame_done <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            r_frame_done <= w_wr_last;
            if (r_state == DRAIN && in_valid) r_overflow <= 1'b1;
        end
    end

    assign out_valid  = (r_state == DRAIN);
    assign out_data   = (r_state == DRAIN) ? r_buf[r_rd_idx] : '0;
    assign out_last   = (r_state == DRAIN) && (r_rd_idx == LAST_IDX);
    assign frame_done = r_frame_done;
    assign overflow   = r_overflow;

endmodule

// File: tb/tb_se_relu_collector.sv
// Self-checking bench for se_relu_collector: queue-based frame model compared every
// cycle, directed scenarios with literal expectations, then a randomized phase.
module tb_se_relu_collector;

    localparam int N = 4;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] in_data = '0;
    logic         in_valid = 1'b0;
    logic [W-1:0] out_data;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic         out_last;
    logic         frame_done;
    logic         overflow;

    int n_vec = 0;
    int n_err = 0;

    se_relu_collector #(.DATA_WIDTH(W), .NUM_CHANNELS(N)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .frame_done(frame_done), .overflow(overflow)
    );

    always #5 clk = ~clk;

    // Behavioural model: a frame is a queue; draining pops from its head.
    bit           m_drain;
    logic [W-1:0] m_cq[$];
    logic [W-1:0] m_dq[$];
    bit           m_fd;
    bit           m_ovf;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_drain = 0; m_cq.delete(); m_dq.delete(); m_fd = 0; m_ovf = 0;
        end else begin
            m_fd = 0;
            if (!m_drain) begin
                if (in_valid) begin
                    m_cq.push_back(in_data);
                    if (m_cq.size() == N) begin
                        m_dq = m_cq; m_cq.delete(); m_drain = 1; m_fd = 1;
                    end
                end
            end else begin
                if (in_valid) m_ovf = 1;
                if (out_ready) begin
                    void'(m_dq.pop_front());
                    if (m_dq.size() == 0) m_drain = 0;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    logic [W-1:0] got[$];
    int           fd_cnt;
    logic [W-1:0] last_data;

    always @(negedge clk) begin
        logic [W-1:0] e_data;
        e_data = (m_drain && m_dq.size() > 0) ? m_dq[0] : '0;
        chk("out_valid", 32'(out_valid), 32'(m_drain));
        chk("out_data", 32'(out_data), 32'(e_data));
        chk("out_last", 32'(out_last), 32'(m_drain && m_dq.size() == 1));
        chk("frame_done", 32'(frame_done), 32'(m_fd));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        if (out_valid && out_ready) begin
            got.push_back(out_data);
            if (out_last) last_data = out_data;
        end
        if (frame_done) fd_cnt++;
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic send(input logic [W-1:0] v);
        in_valid = 1'b1; in_data = v; tick(); in_valid = 1'b0; in_data = '0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic drain_all();
        out_ready = 1'b1;
        for (int i = 0; i < 40 && out_valid; i++) tick();
        chk("drain_timeout", 32'(out_valid), 32'd0);
        out_ready = 1'b0;
    endtask

    task automatic chk_got(input string name, input logic [W-1:0] e0, input logic [W-1:0] e1,
                           input logic [W-1:0] e2, input logic [W-1:0] e3);
        chk({name, "_count"}, 32'(got.size()), 32'd4);
        if (got.size() == 4) begin
            chk({name, "_d0"}, 32'(got[0]), 32'(e0));
            chk({name, "_d1"}, 32'(got[1]), 32'(e1));
            chk({name, "_d2"}, 32'(got[2]), 32'(e2));
            chk({name, "_d3"}, 32'(got[3]), 32'(e3));
        end
    endtask

    task automatic clear_mon();
        got.delete(); fd_cnt = 0; last_data = '0;
    endtask

    initial begin
        logic [W-1:0] v[4];
        idle(3);
        rst = 1'b0;
        idle(2);

        // Basic frame
        clear_mon();
        for (int i = 1; i <= 4; i++) send(W'(i));
        chk("basic_valid_rise", 32'(out_valid), 32'd1);
        chk("basic_first", 32'(out_data), 32'd1);
        drain_all();
        chk_got("basic", 16'd1, 16'd2, 16'd3, 16'd4);
        chk("basic_fd_cnt", 32'(fd_cnt), 32'd1);
        chk("basic_last_data", 32'(last_data), 32'd4);
        idle(2);

        // Gapped input
        clear_mon();
        send(16'd10); idle(2); send(16'd0); idle(1); send(16'd20); idle(3);
        chk("gap_fd_early", 32'(fd_cnt), 32'd0);
        send(16'd30);
        drain_all();
        chk_got("gap", 16'd10, 16'd0, 16'd20, 16'd30);
        chk("gap_fd_cnt", 32'(fd_cnt), 32'd1);

        // Backpressure
        clear_mon();
        for (int i = 0; i < 4; i++) begin v[i] = W'($urandom); send(v[i]); end
        for (int i = 0; i < 3; i++) begin
            chk("bp_hold_valid", 32'(out_valid), 32'd1);
            chk("bp_hold_data", 32'(out_data), 32'(v[0]));
            tick();
        end
        drain_all();
        chk_got("bp", v[0], v[1], v[2], v[3]);

        // Overflow during drain
        clear_mon();
        for (int i = 0; i < 4; i++) send(W'(100 + i));
        send(16'hFFFF);
        chk("ovf_set", 32'(overflow), 32'd1);
        drain_all();
        chk_got("ovf_data", 16'd100, 16'd101, 16'd102, 16'd103);
        chk("ovf_sticky", 32'(overflow), 32'd1);
        clear_mon();
        for (int i = 0; i < 4; i++) send(W'(200 + i));
        drain_all();
        chk_got("ovf_next", 16'd200, 16'd201, 16'd202, 16'd203);

        // Reset mid-frame
        clear_mon();
        send(16'd77); send(16'd88);
        rst = 1'b1; tick(); rst = 1'b0; idle(1);
        for (int i = 5; i <= 8; i++) send(W'(i));
        drain_all();
        chk_got("rst_mid", 16'd5, 16'd6, 16'd7, 16'd8);
        chk("rst_ovf", 32'(overflow), 32'd0);

        // Back-to-back frames
        clear_mon();
        for (int i = 0; i < 4; i++) send(W'(300 + i));
        out_ready = 1'b1;
        for (int i = 0; i < 40 && out_valid; i++) begin
            if (out_last) begin tick(); break; end
            tick();
        end
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(W'(400 + i));
        drain_all();
        chk("b2b_count", 32'(got.size()), 32'd8);
        if (got.size() == 8) begin
            chk("b2b_first_of_2nd", 32'(got[4]), 32'd400);
            chk("b2b_last_of_2nd", 32'(got[7]), 32'd403);
        end
        chk("b2b_ovf", 32'(overflow), 32'd0);

        // Randomized traffic, occasional reset
        for (int c = 0; c < 600; c++) begin
            in_valid  = ($urandom_range(0, 2) != 0);
            in_data   = W'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 149) == 0) begin
                rst = 1'b1; tick(); rst = 1'b0;
            end else begin
                tick();
            end
        end
        in_valid = 1'b0; out_ready = 1'b0;
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/se_relu_collector.md
SE_RELU_COLLECTOR -- requirements
Module: se_relu_collector

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 16, giving the sample width in bits.
REQ-002 The block SHALL have parameter NUM_CHANNELS, default 16, giving the samples per frame; legal range is 2 or more.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 The block SHALL have port in_data, input, DATA_WIDTH bits: unsigned ReLU output sample.
REQ-006 The block SHALL have port in_valid, input, 1 bit: in_data is valid this cycle; the input has no backpressure.
REQ-007 The block SHALL have port out_data, output, DATA_WIDTH bits: the buffered sample presented downstream.
REQ-008 The block SHALL have port out_valid, output, 1 bit: out_data is valid.
REQ-009 The block SHALL have port out_ready, input, 1 bit: the downstream side accepts out_data.
REQ-010 The block SHALL have port out_last, output, 1 bit: the current out_data is channel NUM_CHANNELS-1.
REQ-011 The block SHALL have port frame_done, output, 1 bit: one-cycle pulse when a full frame has been captured.
REQ-012 The block SHALL have port overflow, output, 1 bit: sticky flag that one or more input samples were dropped.

Function
REQ-013 The block SHALL hold a register buffer buf[0..NUM_CHANNELS-1] of DATA_WIDTH bits, a write index wr_idx and a read index rd_idx, each $clog2(NUM_CHANNELS) bits wide.
REQ-014 The state machine SHALL have exactly two states, COLLECT and DRAIN.
REQ-015 In COLLECT, in_valid=1 SHALL write in_data to buf[wr_idx] and increment wr_idx at the same edge; in_valid=0 SHALL leave all state unchanged.
REQ-016 A COLLECT write with wr_idx=NUM_CHANNELS-1 SHALL do all of the following at that edge: move to DRAIN, set rd_idx=0, set wr_idx=0, and assert frame_done for exactly the following cycle.
REQ-017 out_valid SHALL be 1 in every DRAIN cycle and 0 in every COLLECT cycle.
REQ-018 In DRAIN, out_data SHALL equal buf[rd_idx]; in COLLECT, out_data SHALL be 0.
REQ-019 out_last SHALL be 1 only when in DRAIN and rd_idx=NUM_CHANNELS-1.
REQ-020 A transfer SHALL occur when out_valid=1 and out_ready=1 in the same cycle; each transfer SHALL increment rd_idx.
REQ-021 While out_valid=1 and out_ready=0, out_data and out_last SHALL remain stable.
REQ-022 A transfer with out_last=1 SHALL return the FSM to COLLECT at that edge.
REQ-023 In DRAIN, in_valid=1 SHALL be dropped without modifying buf, and SHALL set overflow=1; this includes the cycle of the final transfer.
REQ-024 overflow SHALL be cleared only by rst.
REQ-025 Latency SHALL be as follows: out_valid rises on the cycle after the final sample is captured; the first out_data is buf[0].
REQ-026 Samples SHALL pass through unmodified; there is no arithmetic, saturation or sign handling.
REQ-027 out_ready SHALL be ignored in COLLECT.

Reset
REQ-028 While rst=1, all outputs SHALL be 0, state SHALL be COLLECT, wr_idx and rd_idx SHALL be 0, and buf SHALL be all zero.
REQ-029 Assertion of rst mid-frame or mid-drain SHALL discard the partial frame; the first in_valid after rst release SHALL write buf[0].

Verification (NUM_CHANNELS=4, DATA_WIDTH=16)
REQ-030 The bench SHALL cover the basic frame: in_valid=1 for 4 cycles with 1,2,3,4, then out_ready=1. Required response: frame_done pulses once; out_valid rises the next cycle; out_data is 1,2,3,4 on 4 consecutive cycles; out_last=1 only with data 4; out_valid=0 afterwards.
REQ-031 The bench SHALL cover gapped input: samples 10,0,20,30 with idle cycles between them. Required response: buffer order is preserved; frame_done fires only after the 4th sample.
REQ-032 The bench SHALL cover backpressure: in DRAIN, out_ready=0 for 3 cycles then 1. Required response: out_data holds buf[0] stable with out_valid=1; draining then completes in order.
REQ-033 The bench SHALL cover overflow: in_valid=1 with 0xFFFF during DRAIN. Required response: overflow=1 from the next cycle and persists; drained data is unchanged; the next frame starts at buf[0].
REQ-034 The bench SHALL cover reset mid-frame: rst pulsed after 2 samples, then 4 new samples 5,6,7,8. Required response: the drain outputs exactly 5,6,7,8; overflow=0.
REQ-035 The bench SHALL cover back-to-back frames: two frames, with the second frame's first in_valid on the cycle after the last transfer. Required response: the second frame is captured and drained correctly; overflow stays 0.
